// File: rtl/rv_core_pkg.sv
// Shared RV32I core constants and types used by the integer register file.
package rv_core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned IDX_W     = $clog2(REG_COUNT);

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]  xlen_t;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam reg_idx_t REG_ZERO_IDX = '0;

endpackage

// File: rtl/rv_rf_clear_seq.sv
// Post-reset clear sequencer: walks x1..x(REG_COUNT-1) one per cycle and
// strobes a zero write into each, holding busy until the sweep finishes.
module rv_rf_clear_seq #(
    parameter int unsigned REG_COUNT = rv_core_pkg::REG_COUNT,
    parameter int unsigned IDX_W     = $clog2(REG_COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             busy,
    output logic             clr_we_c,
    output logic [IDX_W-1:0] clr_ptr
);
    import rv_core_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_COUNT - 1);

    rf_state_t state;

    // Pointer stops at the last register, so it never wraps back onto x0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= RF_CLEAR;
            clr_ptr <= IDX_W'(1);
            busy    <= 1'b1;
        end else if (state == RF_CLEAR) begin
            if (clr_ptr == LAST_IDX) begin
                state <= RF_READY;
                busy  <= 1'b0;
            end else begin
                clr_ptr <= clr_ptr + IDX_W'(1);
            end
        end
    end

    assign clr_we_c = reset && (state == RF_CLEAR);

endmodule

// File: rtl/rv_register_file.sv
// RV32I integer register file: two registered read ports, one write port,
// post-reset clear sweep. Optional forwarding under RV_REGFILE_BYPASS_EN.
module rv_register_file #(
    parameter int unsigned XLEN      = rv_core_pkg::XLEN,
    parameter int unsigned REG_COUNT = rv_core_pkg::REG_COUNT,
    parameter int unsigned IDX_W     = $clog2(REG_COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd1_en,
    input  logic [IDX_W-1:0] rd1_idx,
    output logic [XLEN-1:0]  rd1_data,
    input  logic             rd2_en,
    input  logic [IDX_W-1:0] rd2_idx,
    output logic [XLEN-1:0]  rd2_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [XLEN-1:0]  wr_data,
    output logic             busy,
    output logic             wr_drop
);
    import rv_core_pkg::*;

    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(REG_ZERO_IDX);

    logic             clr_we_c;
    logic [IDX_W-1:0] clr_ptr;
    logic             ext_we_c;
    logic [XLEN-1:0]  rd1_next_c;
    logic [XLEN-1:0]  rd2_next_c;
    logic [XLEN-1:0]  mem [REG_COUNT];

    rv_rf_clear_seq #(
        .REG_COUNT (REG_COUNT),
        .IDX_W     (IDX_W)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we_c (clr_we_c),
        .clr_ptr  (clr_ptr)
    );

    assign ext_we_c = reset && !busy && wr_en && (wr_idx != ZERO_IDX);

    // Storage has no reset; the sweep owns the write port while busy.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_ptr] <= '0;
        end else if (ext_we_c) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd1_next_c = mem[rd1_idx];
        rd2_next_c = mem[rd2_idx];
`ifdef RV_REGFILE_BYPASS_EN
        if (wr_en && (wr_idx == rd1_idx)) begin
            rd1_next_c = wr_data;
        end
        if (wr_en && (wr_idx == rd2_idx)) begin
            rd2_next_c = wr_data;
        end
`endif
        if (rd1_idx == ZERO_IDX) begin
            rd1_next_c = '0;
        end
        if (rd2_idx == ZERO_IDX) begin
            rd2_next_c = '0;
        end
    end

    // Read data and drop flag; reads during the sweep return zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd1_data <= '0;
            rd2_data <= '0;
            wr_drop  <= 1'b0;
        end else begin
            wr_drop <= busy && wr_en;
            if (rd1_en) begin
                rd1_data <= busy ? '0 : rd1_next_c;
            end
            if (rd2_en) begin
                rd2_data <= busy ? '0 : rd2_next_c;
            end
        end
    end

endmodule
